// File: rtl/hmac_stream_feeder.sv
// Byte-stream to 32-bit word feeder for an HMAC/hash core; captures the result tag.
// Optional TAG_CHECK_EN adds expected_tag/tag_match comparison against the result.
module hmac_stream_feeder #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         hash_start,
    input  logic         hash_ready,
    output logic         hash_update,
    output logic [31:0]  hash_data,
    output logic [2:0]   hash_bytes_valid,
    output logic         hash_finalize,
    input  logic         hash_valid,
    input  logic [255:0] hash_in,
    output logic         done,
    output logic [255:0] tag,
    output logic         timeout
`ifdef TAG_CHECK_EN
    ,
    input  logic [255:0] expected_tag,
    output logic         tag_match
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_READY,
        COLLECT,
        FINAL,
        WAIT_HASH
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   word_q, word_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          upd_q, upd_d;
    logic [31:0]   data_q, data_d;
    logic [2:0]    bv_q, bv_d;
    logic          fin_q, fin_d;
    logic          done_q, done_d;
    logic          tmo_p_q, tmo_p_d;
    logic [255:0]  tag_q, tag_d;
    logic [31:0]   word_n;
`ifdef TAG_CHECK_EN
    logic          match_q, match_d;
`endif

    assign in_ready         = (state_q == COLLECT);
    assign hash_start       = (state_q == START);
    assign hash_update      = upd_q;
    assign hash_data        = data_q;
    assign hash_bytes_valid = bv_q;
    assign hash_finalize    = fin_q;
    assign done             = done_q;
    assign tag              = tag_q;
    assign timeout          = tmo_p_q;
`ifdef TAG_CHECK_EN
    assign tag_match        = match_q;
`endif

    // Incoming byte lands at the lane selected by the byte counter, MSB first.
    assign word_n = word_q | ({in_data, 24'h0} >> {cnt_q, 3'b000});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        tmo_d   = tmo_q;
        upd_d   = 1'b0;
        data_d  = data_q;
        bv_d    = bv_q;
        fin_d   = 1'b0;
        done_d  = 1'b0;
        tmo_p_d = 1'b0;
        tag_d   = tag_q;
`ifdef TAG_CHECK_EN
        match_d = match_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d  = 2'd0;
                word_d = 32'h0;
                if (in_valid) state_d = START;
            end
            START: state_d = WAIT_READY;
            WAIT_READY: begin
                if (hash_ready) state_d = COLLECT;
            end
            COLLECT: begin
                if (in_valid) begin
                    if (cnt_q == 2'd3 || in_last) begin
                        upd_d  = 1'b1;
                        data_d = word_n;
                        bv_d   = {1'b0, cnt_q} + 3'd1;
                        word_d = 32'h0;
                        cnt_d  = 2'd0;
                    end else begin
                        word_d = word_n;
                        cnt_d  = cnt_q + 2'd1;
                    end
                    if (in_last) state_d = FINAL;
                end
            end
            FINAL: begin
                fin_d   = 1'b1;
                tmo_d   = '0;
                state_d = WAIT_HASH;
            end
            WAIT_HASH: begin
                if (hash_valid) begin
                    tag_d   = hash_in;
                    done_d  = 1'b1;
`ifdef TAG_CHECK_EN
                    match_d = (hash_in == expected_tag);
`endif
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_p_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            word_q  <= 32'h0;
            tmo_q   <= '0;
            upd_q   <= 1'b0;
            data_q  <= 32'h0;
            bv_q    <= 3'd0;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
            tmo_p_q <= 1'b0;
            tag_q   <= 256'h0;
`ifdef TAG_CHECK_EN
            match_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            tmo_q   <= tmo_d;
            upd_q   <= upd_d;
            data_q  <= data_d;
            bv_q    <= bv_d;
            fin_q   <= fin_d;
            done_q  <= done_d;
            tmo_p_q <= tmo_p_d;
            tag_q   <= tag_d;
`ifdef TAG_CHECK_EN
            match_q <= match_d;
`endif
        end
    end

endmodule

// File: tb/tb_hmac_stream_feeder.sv
// Scoreboard bench for hmac_stream_feeder: directed frames, timeout and mid-frame reset.
module tb_hmac_stream_feeder;

    localparam logic [255:0] HMAC1 =
        256'hb0344c61d8db38535ca8afceaf0bf12b881dc200c9833da726e9376c2e32cff7;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  bv;
        int          gap;
    } upd_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'h0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic         hash_start;
    logic         hash_ready = 1'b0;
    logic         hash_update;
    logic [31:0]  hash_data;
    logic [2:0]   hash_bytes_valid;
    logic         hash_finalize;
    logic         hash_valid = 1'b0;
    logic [255:0] hash_in = 256'h0;
    logic         done;
    logic [255:0] tag;
    logic         timeout;
`ifdef TAG_CHECK_EN
    logic [255:0] expected_tag = 256'h0;
    logic         tag_match;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_upd_cyc = 0;
    int fin_cyc = 0;
    int done_cnt = 0;
    bit fin_seen = 0;
    bit tmo_seen = 0;
    logic [255:0] last_tag = 256'h0;
    upd_t exp_q[$];
    logic [255:0] exp_tag_q[$];
    byte unsigned frm[$];

    hmac_stream_feeder #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .hash_start(hash_start), .hash_ready(hash_ready),
        .hash_update(hash_update), .hash_data(hash_data),
        .hash_bytes_valid(hash_bytes_valid), .hash_finalize(hash_finalize),
        .hash_valid(hash_valid), .hash_in(hash_in),
        .done(done), .tag(tag), .timeout(timeout)
`ifdef TAG_CHECK_EN
        , .expected_tag(expected_tag), .tag_match(tag_match)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string t, input logic [255:0] o,
                         input logic [255:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask

    // Output monitor: pops the scoreboard on every update/done.
    always @(negedge clk) begin
        if (!rst) begin
            if (32'(hash_update) + 32'(hash_start) + 32'(hash_finalize) > 1)
                check("exclusive", 1'b1, 1'b0);
            if (hash_update) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_update", {224'h0, hash_data}, 256'h0);
                end else begin
                    upd_t u;
                    u = exp_q.pop_front();
                    check("upd_data", {224'h0, hash_data}, {224'h0, u.data});
                    check("upd_bv", {253'h0, hash_bytes_valid}, {253'h0, u.bv});
                    if (u.gap > 0)
                        check("upd_gap", 256'(cyc - last_upd_cyc), 256'(u.gap));
                end
                last_upd_cyc = cyc;
            end
            if (hash_finalize) begin
                check("fin_after_upd", 256'(cyc - last_upd_cyc), 256'd1);
                fin_cyc = cyc;
                fin_seen = 1;
            end
            if (timeout) begin
                check("tmo_delay", 256'(cyc - fin_cyc), 256'd16);
                check("tmo_tag_hold", tag, last_tag);
                tmo_seen = 1;
            end
            if (done) begin
                done_cnt++;
                if (exp_tag_q.size() == 0)
                    check("unexpected_done", tag, 256'h0);
                else
                    check("done_tag", tag, exp_tag_q.pop_front());
                last_tag = tag;
            end
        end
    end

    // Drives frm; abort_after>0 stops after that many accepted bytes.
    task automatic send_frame(input int abort_after);
        int idx = 0;
        int n = frm.size();
        if (abort_after == 0) begin
            for (int w = 0; w * 4 < n; w++) begin
                upd_t u;
                int nb = (n - w * 4 > 4) ? 4 : n - w * 4;
                u.data = 32'h0;
                for (int k = 0; k < nb; k++)
                    u.data[31-8*k -: 8] = frm[w*4+k];
                u.bv = 3'(nb);
                u.gap = (w == 0) ? 0 : nb;
                exp_q.push_back(u);
            end
        end
        for (int t = 0; t < 200 && idx < n; t++) begin
            bit acc;
            @(negedge clk);
            if (abort_after > 0 && idx == abort_after) return;
            in_valid = 1'b1;
            in_data  = frm[idx];
            in_last  = (idx == n - 1);
            #1;
            acc = in_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("frame_accepted", 256'(idx), 256'(n));
    endtask

    task automatic respond(input logic [255:0] h, input bit give);
        int t = 0;
        while (!fin_seen && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("fin_seen", 256'(fin_seen), 256'd1);
        fin_seen = 0;
        if (give) begin
            repeat (2) @(negedge clk);
            hash_valid = 1'b1;
            hash_in    = h;
            exp_tag_q.push_back(h);
            @(negedge clk);
            hash_valid = 1'b0;
            repeat (3) @(negedge clk);
        end else begin
            t = 0;
            tmo_seen = 0;
            while (!tmo_seen && t < 40) begin
                @(negedge clk);
                t++;
            end
            check("tmo_seen", 256'(tmo_seen), 256'd1);
        end
    endtask

    task automatic hi_there();
        frm = '{8'h48, 8'h69, 8'h20, 8'h54, 8'h68, 8'h65, 8'h72, 8'h65};
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 256'(in_ready), 256'd0);
        check("rst_start", 256'(hash_start), 256'd0);
        check("rst_update", 256'(hash_update), 256'd0);
        check("rst_fin", 256'(hash_finalize), 256'd0);
        check("rst_done", 256'(done), 256'd0);
        check("rst_timeout", 256'(timeout), 256'd0);
        check("rst_data", {224'h0, hash_data}, 256'h0);
        check("rst_bv", {253'h0, hash_bytes_valid}, 256'h0);
        check("rst_tag", tag, 256'h0);
        rst = 1'b0;

        // Hi There, with hash_ready held off a few cycles
        fork
            begin
                repeat (6) @(negedge clk);
                hash_ready = 1'b1;
            end
        join_none
`ifdef TAG_CHECK_EN
        expected_tag = HMAC1;
`endif
        hi_there();
        send_frame(0);
        respond(HMAC1, 1);
        check("tag_hi", tag, HMAC1);
`ifdef TAG_CHECK_EN
        check("tag_match_1", 256'(tag_match), 256'd1);
`endif

        frm = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        send_frame(0);
        respond(256'h1234, 1);

        frm = '{8'hAA};
        send_frame(0);
        respond({8'hAA, 240'h0, 8'h55}, 1);
`ifdef TAG_CHECK_EN
        check("tag_match_0", 256'(tag_match), 256'd0);
`endif

        d0 = done_cnt;
        frm = '{8'h61, 8'h62, 8'h63};
        send_frame(0);
        respond(256'h0, 0);
        check("no_done_on_tmo", 256'(done_cnt), 256'(d0));
        check("tag_after_tmo", tag, {8'hAA, 240'h0, 8'h55});

        // Abort after three bytes via asynchronous reset
        hi_there();
        send_frame(3);
        rst = 1'b1;
        #1;
        check("abort_in_ready", 256'(in_ready), 256'd0);
        check("abort_outs", 256'({hash_start, hash_update, hash_finalize,
                                  done, timeout}), 256'd0);
        check("abort_tag", tag, 256'h0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        last_tag = 256'h0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifdef TAG_CHECK_EN
        expected_tag = HMAC1 ^ 256'h1;
`endif
        hi_there();
        send_frame(0);
        respond(HMAC1, 1);
        check("tag_hi2", tag, HMAC1);
`ifdef TAG_CHECK_EN
        check("tag_match_flip", 256'(tag_match), 256'd0);
`endif

        repeat (5) @(negedge clk);
        check("upd_queue_empty", 256'(exp_q.size()), 256'd0);
        check("tag_queue_empty", 256'(exp_tag_q.size()), 256'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hmac_stream_feeder.md
HMAC_STREAM_FEEDER -- requirements
Module: hmac_stream_feeder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the max cycles waited in WAIT_HASH before the frame is aborted.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on posedge clk.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 in_valid  input  1  SHALL mark in_data/in_last valid.
REQ-005 in_data  input  8  SHALL carry one message byte.
REQ-006 in_last  input  1  SHALL mark the final byte of a frame; every frame has at least one byte.
REQ-007 in_ready  output  1  SHALL accept a byte on a cycle where in_valid && in_ready.
REQ-008 hash_start  output  1  SHALL pulse one cycle to begin a hash.
REQ-009 hash_ready  input  1  SHALL indicate the core has accepted start and takes updates.
REQ-010 hash_update  output  1  SHALL pulse with a valid hash_data word.
REQ-011 hash_data  output  32  SHALL carry packed bytes, first byte in [31:24].
REQ-012 hash_bytes_valid  output  3  SHALL give the byte count (1-4) in hash_data, left-aligned.
REQ-013 hash_finalize  output  1  SHALL pulse one cycle after the last update.
REQ-014 hash_valid  input  1  SHALL qualify hash_in.
REQ-015 hash_in  input  256  SHALL carry the core's result.
REQ-016 done  output  1  SHALL pulse one cycle when tag is updated.
REQ-017 tag  output  256  SHALL hold the last captured hash.
REQ-018 timeout  output  1  SHALL pulse one cycle on WAIT_HASH timeout.

Function
REQ-019 States SHALL be IDLE, START, WAIT_READY, COLLECT, FINAL, WAIT_HASH.
REQ-020 IDLE: in_ready=0; in_valid=1 -> START (byte not consumed).
REQ-021 START: hash_start=1 for exactly one cycle -> WAIT_READY.
REQ-022 WAIT_READY: hold until hash_ready=1 -> COLLECT; no timeout.
REQ-023 COLLECT: in_ready=1; one byte per cycle, no bubbles; byte k of a word goes to bits [31-8k:24-8k].
REQ-024 On acceptance of the 4th byte of a word, hash_update SHALL assert the next cycle with bytes_valid=4; collection continues uninterrupted.
REQ-025 On acceptance of in_last, hash_update SHALL assert the next cycle with the partial word (unused low bytes zero, bytes_valid=1-4); in_ready=0 from that cycle; -> FINAL.
REQ-026 FINAL: hash_finalize=1 exactly one cycle, which is the cycle after the last hash_update -> WAIT_HASH.
REQ-027 WAIT_HASH: hash_valid=1 -> tag<=hash_in, done pulses the next cycle, -> IDLE.
REQ-028 WAIT_HASH counter SHALL reset on entry; at TIMEOUT_CYCLES cycles without hash_valid, timeout pulses, tag unchanged, -> IDLE.
REQ-029 hash_update, hash_start, hash_finalize SHALL never assert in the same cycle.
REQ-030 hash_valid outside WAIT_HASH SHALL be ignored.

Reset
REQ-031 rst SHALL force IDLE immediately; in_ready, hash_start, hash_update, hash_finalize, done, timeout=0; hash_data, hash_bytes_valid, tag=0; byte counter and timeout counter=0.
REQ-032 Reset mid-frame SHALL discard the partial word with no finalize issued; next frame starts clean.

Configuration
REQ-033 With TAG_CHECK_EN defined: ports expected_tag (input 256) and tag_match (output 1) SHALL exist; tag_match SHALL equal (hash_in==expected_tag) registered in the cycle done pulses and held until the next done or reset (reset 0).
REQ-034 Without TAG_CHECK_EN: those ports and the comparator SHALL be absent; all other behaviour identical.

Verification
REQ-035 "Hi There" (8 bytes, last on 'e') -> updates 0x48692054/4, 0x68657265/4 on consecutive-per-word cycles, finalize next cycle; core returns b0344c61...2e32cff7 -> done pulse, tag equal.
REQ-036 "abcde" -> updates 0x61626364/4 then 0x65000000/1, finalize the following cycle.
REQ-037 Single byte 0xAA with last -> one update 0xAA000000/1, finalize, then done.
REQ-038 hash_valid withheld, TIMEOUT_CYCLES=16 -> timeout pulses 16 cycles after WAIT_HASH entry, done never pulses, tag unchanged.
REQ-039 rst asserted after 3 bytes of a frame -> all outputs 0 immediately; next frame "Hi There" produces REQ-035 sequence exactly.
REQ-040 TAG_CHECK_EN, expected_tag=b0344c61...2e32cff7 -> tag_match=1; flip bit 0 of expected_tag -> tag_match=0.
